// File: rtl/btn_event_if.sv
// Button-event bus: debounced level and tick strobe in, one-cycle event pulses out.
// Plus the FSM state for observation.
interface btn_event_if;
   logic       sample_tick;
   logic       bn_db;
   logic       press_pulse;
   logic       short_pulse;
   logic       long_pulse;
   logic       repeat_pulse;
   logic       release_pulse;
   logic       held;
   logic [1:0] state_dbg;

   // The event outputs are fire-and-forget strobes with no backpressure.
   // The consumer must act on a pulse in the cycle it is high.
   modport master (
      output sample_tick, bn_db,
      input  press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse,
             held, state_dbg
   );

   modport slave (
      input  sample_tick, bn_db,
      output press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse,
             held, state_dbg
   );
endinterface

// File: rtl/btn_event.sv
// Turns a debounced button level into press / short / long / repeat / release events.
// Hold times are counted in sample_tick periods.
module btn_event #(
   parameter int LONG_COUNT   = 500,
   parameter int REPEAT_COUNT = 100
) (
   input  logic        clk,
   input  logic        rst,
   btn_event_if.slave  bus
);
   localparam int MAX_COUNT = (LONG_COUNT > REPEAT_COUNT) ? LONG_COUNT : REPEAT_COUNT;
   localparam int CW        = ($clog2(MAX_COUNT) < 2) ? 2 : $clog2(MAX_COUNT);
   localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_COUNT - 1);
   localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_COUNT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRESS  = 2'd1,
      REPEAT = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic          bn_prev;
   logic          rise;
   logic          fall;

   assign rise          = bus.bn_db & ~bn_prev;
   assign fall          = ~bus.bn_db & bn_prev;
   assign bus.state_dbg = state;

   // bn_prev resets high so a button held through reset must be released
   // and pressed again before it produces any event.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         count             <= '0;
         bn_prev           <= 1'b1;
         bus.press_pulse   <= 1'b0;
         bus.short_pulse   <= 1'b0;
         bus.long_pulse    <= 1'b0;
         bus.repeat_pulse  <= 1'b0;
         bus.release_pulse <= 1'b0;
         bus.held          <= 1'b0;
      end else begin
         bn_prev           <= bus.bn_db;
         bus.press_pulse   <= 1'b0;
         bus.short_pulse   <= 1'b0;
         bus.long_pulse    <= 1'b0;
         bus.repeat_pulse  <= 1'b0;
         bus.release_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  bus.press_pulse <= 1'b1;
                  bus.held        <= 1'b1;
                  count           <= '0;
                  state           <= PRESS;
               end
            end
            PRESS: begin
               // A fall beats a coincident terminal tick.
               if (fall) begin
                  bus.short_pulse   <= 1'b1;
                  bus.release_pulse <= 1'b1;
                  bus.held          <= 1'b0;
                  state             <= IDLE;
               end else if (bus.sample_tick) begin
                  if (count == LONG_LAST) begin
                     bus.long_pulse <= 1'b1;
                     count          <= '0;
                     state          <= REPEAT;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            REPEAT: begin
               if (fall) begin
                  bus.release_pulse <= 1'b1;
                  bus.held          <= 1'b0;
                  state             <= IDLE;
               end else if (bus.sample_tick) begin
                  if (count == REPEAT_LAST) begin
                     bus.repeat_pulse <= 1'b1;
                     count            <= '0;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            default: begin
               bus.held <= 1'b0;
               count    <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_btn_event.sv
// Bench for btn_event: directed scenarios plus random button activity.
// Checked every cycle against an event-level model of the button.
module tb_btn_event;
   localparam int LONG_C = 4;
   localparam int REP_C  = 2;

   logic clk;
   logic rst;
   btn_event_if bif();

   btn_event #(.LONG_COUNT(LONG_C), .REPEAT_COUNT(REP_C)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- tick generator ----------------
   bit tick_en   = 1'b1;
   bit tick_rand = 1'b0;
   int tick_div  = 0;

   initial bif.sample_tick = 1'b0;
   always @(negedge clk) begin
      if (tick_rand) begin
         bif.sample_tick = ($urandom_range(0, 2) == 0);
      end else begin
         tick_div        = (tick_div == 3) ? 0 : tick_div + 1;
         bif.sample_tick = tick_en && (tick_div == 0);
      end
   end

   // ---------------- reference model ----------------
   // Tracks ticks elapsed since the press began.
   // Long fires when that total reaches LONG_C.
   // Repeats fire on every further multiple of REP_C.
   // Vector order: press, short, long, repeat, release, held.
   logic [5:0] exp_q[$];
   bit m_prev  = 1'b1;
   bit m_track = 1'b0;
   int m_ticks = 0;

   always @(posedge clk) begin
      logic [5:0] e;
      bit r, f;
      e = '0;
      if (rst) begin
         m_prev  = 1'b1;
         m_track = 1'b0;
         m_ticks = 0;
      end else begin
         r      = bif.bn_db && !m_prev;
         f      = !bif.bn_db && m_prev;
         m_prev = bif.bn_db;
         if (!m_track) begin
            if (r) begin
               e[5]    = 1'b1;
               m_track = 1'b1;
               m_ticks = 0;
            end
         end else if (f) begin
            e[1]    = 1'b1;
            e[4]    = (m_ticks < LONG_C);
            m_track = 1'b0;
         end else if (bif.sample_tick) begin
            m_ticks++;
            if (m_ticks == LONG_C)
               e[3] = 1'b1;
            else if (m_ticks > LONG_C && ((m_ticks - LONG_C) % REP_C) == 0)
               e[2] = 1'b1;
         end
         e[0] = m_track;
      end
      exp_q.push_back(e);
   end

   // ---------------- scoreboard ----------------
   logic [5:0] dut_vec;
   assign dut_vec = {bif.press_pulse, bif.short_pulse, bif.long_pulse,
                     bif.repeat_pulse, bif.release_pulse, bif.held};

   always @(negedge clk) begin
      logic [5:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (dut_vec !== e) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t dut=%b exp=%b (press,short,long,repeat,release,held)",
                     $time, dut_vec, e);
         end
      end
   end

   // DUT event counters for the hand-computed scenario checks
   int c_press, c_short, c_long, c_rep, c_rel;
   always @(negedge clk) begin
      if (bif.press_pulse)   c_press++;
      if (bif.short_pulse)   c_short++;
      if (bif.long_pulse)    c_long++;
      if (bif.repeat_pulse)  c_rep++;
      if (bif.release_pulse) c_rel++;
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_cnt();
      c_press = 0; c_short = 0; c_long = 0; c_rep = 0; c_rel = 0;
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   // Advance until n ticks have been seen in cycles after the current one.
   // Optionally drop the button in the cycle of the last tick.
   task automatic run_ticks(input int n, input bit drop_at_last);
      int c = 0;
      int guard = 0;
      while (c < n && guard < 400) begin
         step();
         guard++;
         if (bif.sample_tick) begin
            c++;
            if (c == n && drop_at_last) bif.bn_db = 1'b0;
         end
      end
      if (c < n) check("tick_budget", c, n);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst       = 1'b1;
      bif.bn_db = 1'b0;
      clear_cnt();
      repeat (3) step();
      check("rst_outputs", int'(dut_vec), 0);
      rst = 1'b0;
      step();

      // 1: short press of 3 ticks
      clear_cnt();
      bif.bn_db = 1'b1;
      run_ticks(3, 1'b0);
      step();
      bif.bn_db = 1'b0;
      repeat (3) step();
      check("s1_press", c_press, 1);
      check("s1_short", c_short, 1);
      check("s1_release", c_rel, 1);
      check("s1_long", c_long, 0);
      check("s1_held_after", int'(bif.held), 0);

      // 2: long hold of 12 ticks
      clear_cnt();
      bif.bn_db = 1'b1;
      run_ticks(12, 1'b0);
      step();
      step();
      bif.bn_db = 1'b0;
      repeat (3) step();
      check("s2_long", c_long, 1);
      check("s2_repeat", c_rep, 4);
      check("s2_release", c_rel, 1);
      check("s2_short", c_short, 0);

      // 3: fall coincides with the 4th tick
      clear_cnt();
      step();
      bif.bn_db = 1'b1;
      run_ticks(4, 1'b1);
      repeat (3) step();
      check("s3_short", c_short, 1);
      check("s3_release", c_rel, 1);
      check("s3_long", c_long, 0);

      // 4: button held through reset
      bif.bn_db = 1'b1;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      clear_cnt();
      run_ticks(10, 1'b0);
      check("s4_no_events", c_press + c_short + c_long + c_rep + c_rel, 0);
      check("s4_held", int'(bif.held), 0);
      bif.bn_db = 1'b0;
      repeat (3) step();
      clear_cnt();
      bif.bn_db = 1'b1;
      repeat (3) step();
      check("s4_repress", c_press, 1);

      // 5: reset while in the repeat phase
      run_ticks(5, 1'b0);
      step();
      check("s5_held_pre", int'(bif.held), 1);
      rst = 1'b1;
      step();
      check("s5_outputs_zero", int'(dut_vec), 0);
      rst = 1'b0;
      clear_cnt();
      step();
      bif.bn_db = 1'b0;
      repeat (4) step();
      check("s5_release", c_rel, 0);
      check("s5_short", c_short, 0);

      // 6: ticks stalled during a hold
      clear_cnt();
      tick_en = 1'b0;
      repeat (2) step();
      bif.bn_db = 1'b1;
      repeat (100) step();
      check("s6_press", c_press, 1);
      check("s6_long_stalled", c_long, 0);
      check("s6_held", int'(bif.held), 1);
      tick_en = 1'b1;
      run_ticks(4, 1'b0);
      step();
      step();
      check("s6_long_resumed", c_long, 1);
      bif.bn_db = 1'b0;
      repeat (3) step();

      // random activity with irregular ticks and occasional resets
      tick_rand = 1'b1;
      for (int i = 0; i < 200; i++) begin
         bif.bn_db = ~bif.bn_db;
         repeat ($urandom_range(1, 25)) step();
         if ($urandom_range(0, 19) == 0) begin
            rst = 1'b1;
            repeat ($urandom_range(1, 2)) step();
            rst = 1'b0;
         end
      end
      bif.bn_db = 1'b0;
      repeat (5) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/btn_event.md
# btn_event

Converts a debounced button level into discrete one-cycle events for the stopwatch control logic: press, short release, long-press and auto-repeat. It sits directly downstream of the button debouncer, shares its `sample_tick` time base (1 ms nominal), and feeds start/stop/lap/reset decoding. All timing is counted in `sample_tick` periods; edge detection runs at full `clk` rate.

## Interface
- `LONG_COUNT`, default 500: ticks the button must stay pressed before `long_pulse`; must be ≥2.
- `REPEAT_COUNT`, default 100: ticks between successive `repeat_pulse` after a long press; must be ≥2.
- `clk` input 1: system clock, 100 MHz.
- `rst` input 1: synchronous, active-high reset.
- `sample_tick` input 1: one-`clk` strobe, same strobe that drives the debouncer.
- `bn_db` input 1: debounced button level, 1 = pressed.
- `press_pulse` output 1: one-cycle pulse on press.
- `short_pulse` output 1: one-cycle pulse on release before the long threshold.
- `long_pulse` output 1: one-cycle pulse when the long threshold is reached.
- `repeat_pulse` output 1: one-cycle pulse every `REPEAT_COUNT` ticks after `long_pulse` while held.
- `release_pulse` output 1: one-cycle pulse on any release from a tracked press.
- `held` output 1: high while a press is being tracked.

## Operation
- Edge detect: `bn_prev` register samples `bn_db` every `clk`. rise = `bn_db & ~bn_prev`; fall = `~bn_db & bn_prev`.
- Counter width: `$clog2(max(LONG_COUNT, REPEAT_COUNT))`, minimum 2 bits. Compare against `N-1`. Never wraps past its terminal value.
- FSM states:
  - IDLE
    - On rise: pulse `press_pulse`, clear count, go to PRESS.
    - Otherwise stay.
  - PRESS
    - On fall: pulse `short_pulse` and `release_pulse`, go to IDLE.
    - Else on `sample_tick` with count == `LONG_COUNT-1`: pulse `long_pulse`, clear count, go to REPEAT.
    - Else on `sample_tick`: count+1.
  - REPEAT
    - On fall: pulse `release_pulse` only, go to IDLE.
    - Else on `sample_tick` with count == `REPEAT_COUNT-1`: pulse `repeat_pulse`, clear count.
    - Else on `sample_tick`: count+1.
- `held` = 1 in PRESS and REPEAT, 0 in IDLE. It is a registered output.
- Simultaneous fall and `sample_tick` at a terminal count: the fall wins. No long or repeat pulse is emitted; the release pulses are emitted.
- The count advances only on `sample_tick` cycles. Non-tick cycles hold it.
- Reset:
  - state = IDLE, count = 0, all pulse outputs 0, `held` = 0.
  - `bn_prev` = 1, so a button held through reset produces no events until it is released and pressed again.
  - Reset asserted mid-press aborts the press silently; no `release_pulse` or `short_pulse` is emitted.

## Timing
- All outputs are registered.
- Event latency: the condition is sampled at clock edge k; the pulse is high for exactly the cycle after edge k and low again after edge k+1.
- `press_pulse` therefore appears 1 `clk` after the first cycle `bn_db`=1.
- `long_pulse` appears 1 `clk` after the `LONG_COUNT`-th `sample_tick` following the press (counting ticks from the cycle after the rise).
- Repeats are spaced exactly `REPEAT_COUNT` ticks apart, the first one `REPEAT_COUNT` ticks after `long_pulse`.
- At most one of `press_pulse`, `long_pulse`, `repeat_pulse` is high in any cycle.
- `short_pulse` is only ever high together with `release_pulse`.
- A press of one `clk` cycle still yields `press_pulse`, then `short_pulse` + `release_pulse` on the following cycle.

## Test plan
Bench setup for all scenarios: `LONG_COUNT`=4, `REPEAT_COUNT`=2, `sample_tick` every 4 clk.

1. Reset with `bn_db`=0, then raise `bn_db` for 3 ticks and drop it.
   - Expect `press_pulse` 1 clk after the rise.
   - Expect `short_pulse` + `release_pulse` 1 clk after the fall.
   - No `long_pulse`; `held` high exactly between the two events.
2. Hold `bn_db`=1 for 12 ticks after the press.
   - Expect `long_pulse` after tick 4, then `repeat_pulse` after ticks 6, 8, 10 and 12.
   - On release: `release_pulse` with `short_pulse`=0.
3. Drop `bn_db` in the same cycle as the 4th tick.
   - Expect `short_pulse` + `release_pulse` and no `long_pulse`.
4. Keep `bn_db`=1 during and after reset release for 10 ticks.
   - Expect no pulses and `held`=0.
   - Then drop, re-raise: expect `press_pulse`.
5. Assert `rst` for one cycle in REPEAT state.
   - Expect all outputs 0 the next cycle and no `release_pulse` when the button later drops.
6. Hold `sample_tick` low while `bn_db`=1 for 100 clk.
   - Expect only `press_pulse` and `held`=1.
   - No `long_pulse` until ticks resume; it then arrives after 4 ticks.
